// File: rtl/bg_pkg.sv
// Shared types and helpers for the background-removal frame sequencer.
package bg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SUM_START = 3'd1,
        ST_SUM_WAIT  = 3'd2,
        ST_ACC       = 3'd3,
        ST_DIV       = 3'd4,
        ST_BG_START  = 3'd5,
        ST_BG_WAIT   = 3'd6,
        ST_DONE      = 3'd7
    } bg_state_t;

    localparam logic [7:0] EXP_MAX = 8'd255;

    // Ceiling log2; 0 and 1 both map to 0 so a single PE adds no total width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bg_seq_div.sv
// Restoring divider by an elaboration-time constant, one quotient bit per cycle, MSB first.
module seq_div
    import bg_pkg::*;
#(
    parameter int N_W = 32,
    parameter int DIV = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    output logic [N_W-1:0] quot,
    output logic           done
);

    localparam int             CNT_W = clog2(N_W + 1);
    localparam logic [N_W:0]   DIV_C = (N_W + 1)'(DIV);

    logic [N_W-1:0]   rem_r;
    logic [N_W-1:0]   dvd_r;
    logic [N_W-1:0]   quot_r;
    logic [CNT_W-1:0] cnt_r;

    logic [N_W:0]     trial_s;
    logic             fits_s;
    logic [N_W-1:0]   rem_nxt_s;
    logic [N_W-1:0]   quot_nxt_s;

    // Trial subtraction for the current step
    always_comb begin
        trial_s = {rem_r, dvd_r[N_W-1]};
        fits_s  = (trial_s >= DIV_C);
        if (fits_s) begin
            rem_nxt_s = N_W'(trial_s - DIV_C);
        end else begin
            rem_nxt_s = trial_s[N_W-1:0];
        end
        quot_nxt_s = {quot_r[N_W-2:0], fits_s};
    end

    // Loading the dividend doubles as the channel-total register
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r  <= '0;
            dvd_r  <= '0;
            quot_r <= '0;
            cnt_r  <= '0;
        end else if (start) begin
            rem_r  <= '0;
            dvd_r  <= dividend;
            quot_r <= '0;
            cnt_r  <= CNT_W'(N_W);
        end else if (cnt_r != '0) begin
            rem_r  <= rem_nxt_s;
            dvd_r  <= {dvd_r[N_W-2:0], 1'b0};
            quot_r <= quot_nxt_s;
            cnt_r  <= cnt_r - CNT_W'(1);
        end
    end

    // The final quotient is presented during the last step so the caller captures it on that edge.
    assign quot = quot_nxt_s;
    assign done = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/bg_frame_ctrl.sv
// Frame sequencer: launches PE summing, averages the per-PE channel sums and launches background removal.
module bg_frame_ctrl
    import bg_pkg::*;
#(
    parameter int NUM_PIXELS = 4,
    parameter int NUM_PROCS  = 1,
    parameter int SUM_W      = 32
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Go,
    input  logic [NUM_PROCS-1:0]       Qsd,
    input  logic [NUM_PROCS-1:0]       Qbgd,
    input  logic [NUM_PROCS*SUM_W-1:0] red_sum,
    input  logic [NUM_PROCS*SUM_W-1:0] green_sum,
    input  logic [NUM_PROCS*SUM_W-1:0] blue_sum,
    output logic                       Start_Sum,
    output logic                       Start_BgRemoval,
    output logic                       Ack,
    output logic [7:0]                 red_exp,
    output logic [7:0]                 green_exp,
    output logic [7:0]                 blue_exp,
    output logic                       Busy,
    output logic                       Done
);

    localparam int TOT_W = SUM_W + clog2(NUM_PROCS);
    localparam int D     = NUM_PROCS * NUM_PIXELS;

    bg_state_t        state_r;
    bg_state_t        next_s;

    logic [TOT_W-1:0] red_tot_s,   green_tot_s,   blue_tot_s;
    logic [TOT_W-1:0] red_q_s,     green_q_s,     blue_q_s;
    logic             red_done_s,  green_done_s,  blue_done_s;
    logic             div_start_s;
    logic             div_done_s;

    logic             start_sum_r;
    logic             start_bg_r;
    logic             ack_r;
    logic             busy_r;
    logic             done_r;
    logic [7:0]       red_exp_r, green_exp_r, blue_exp_r;

    function automatic logic [7:0] sat_exp(input logic [TOT_W-1:0] q);
        if (q > TOT_W'(EXP_MAX)) begin
            return EXP_MAX;
        end else begin
            return q[7:0];
        end
    endfunction

    // Reduce the per-PE slices into one total per channel
    always_comb begin
        red_tot_s   = '0;
        green_tot_s = '0;
        blue_tot_s  = '0;
        for (int k = 0; k < NUM_PROCS; k++) begin
            red_tot_s   = red_tot_s   + TOT_W'(red_sum[k*SUM_W +: SUM_W]);
            green_tot_s = green_tot_s + TOT_W'(green_sum[k*SUM_W +: SUM_W]);
            blue_tot_s  = blue_tot_s  + TOT_W'(blue_sum[k*SUM_W +: SUM_W]);
        end
    end

    assign div_start_s = (state_r == ST_ACC);
    assign div_done_s  = red_done_s & green_done_s & blue_done_s;

    seq_div #(.N_W(TOT_W), .DIV(D)) u_div_red (
        .clk(Clk), .reset(Reset), .start(div_start_s), .dividend(red_tot_s),
        .quot(red_q_s), .done(red_done_s)
    );

    seq_div #(.N_W(TOT_W), .DIV(D)) u_div_green (
        .clk(Clk), .reset(Reset), .start(div_start_s), .dividend(green_tot_s),
        .quot(green_q_s), .done(green_done_s)
    );

    seq_div #(.N_W(TOT_W), .DIV(D)) u_div_blue (
        .clk(Clk), .reset(Reset), .start(div_start_s), .dividend(blue_tot_s),
        .quot(blue_q_s), .done(blue_done_s)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; done flags only matter inside their own wait state
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE:      next_s = Go ? ST_SUM_START : ST_IDLE;
            ST_SUM_START: next_s = ST_SUM_WAIT;
            ST_SUM_WAIT:  next_s = (&Qsd) ? ST_ACC : ST_SUM_WAIT;
            ST_ACC:       next_s = ST_DIV;
            ST_DIV:       next_s = div_done_s ? ST_BG_START : ST_DIV;
            ST_BG_START:  next_s = ST_BG_WAIT;
            ST_BG_WAIT:   next_s = (&Qbgd) ? ST_DONE : ST_BG_WAIT;
            ST_DONE:      next_s = ST_IDLE;
            default:      next_s = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            start_sum_r <= 1'b0;
            start_bg_r  <= 1'b0;
            ack_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            red_exp_r   <= 8'd0;
            green_exp_r <= 8'd0;
            blue_exp_r  <= 8'd0;
        end else begin
            start_sum_r <= (next_s == ST_SUM_START);
            start_bg_r  <= (next_s == ST_BG_START);
            ack_r       <= (next_s != ST_IDLE) && (next_s != ST_SUM_START);
            busy_r      <= (next_s != ST_IDLE);
            done_r      <= (next_s == ST_DONE);
            if ((state_r == ST_DIV) && div_done_s) begin
                red_exp_r   <= sat_exp(red_q_s);
                green_exp_r <= sat_exp(green_q_s);
                blue_exp_r  <= sat_exp(blue_q_s);
            end
        end
    end

    assign Start_Sum       = start_sum_r;
    assign Start_BgRemoval = start_bg_r;
    assign Ack             = ack_r;
    assign Busy            = busy_r;
    assign Done            = done_r;
    assign red_exp         = red_exp_r;
    assign green_exp       = green_exp_r;
    assign blue_exp        = blue_exp_r;

endmodule

// File: tb/tb_bg_frame_ctrl.sv
// Scoreboard bench for bg_frame_ctrl: three configurations share stimulus through a select mux.
module tb_bg_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [1:0]  qsd, qbgd;
    logic [31:0] r_lo, r_hi, g_lo, g_hi, b_lo, b_hi;
    int          sel;

    logic        a_ss, a_sbg, a_ack, a_busy, a_done;
    logic [7:0]  a_r, a_g, a_b;
    logic        b_ss, b_sbg, b_ack, b_busy, b_done;
    logic [7:0]  b_r, b_g, b_b;
    logic        c_ss, c_sbg, c_ack, c_busy, c_done;
    logic [7:0]  c_r, c_g, c_b;

    logic        o_ss, o_sbg, o_ack, o_busy, o_done;
    logic [7:0]  o_r, o_g, o_b;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    int          ss_cnt = 0;
    int          sbg_cnt = 0;

    always #5 clk = ~clk;

    bg_frame_ctrl #(.NUM_PIXELS(4), .NUM_PROCS(1), .SUM_W(32)) dut_a (
        .Clk(clk), .Reset(rst), .Go(go && (sel == 0)), .Qsd(qsd[0]), .Qbgd(qbgd[0]),
        .red_sum(r_lo), .green_sum(g_lo), .blue_sum(b_lo),
        .Start_Sum(a_ss), .Start_BgRemoval(a_sbg), .Ack(a_ack),
        .red_exp(a_r), .green_exp(a_g), .blue_exp(a_b), .Busy(a_busy), .Done(a_done)
    );

    bg_frame_ctrl #(.NUM_PIXELS(4), .NUM_PROCS(2), .SUM_W(32)) dut_b (
        .Clk(clk), .Reset(rst), .Go(go && (sel == 1)), .Qsd(qsd), .Qbgd(qbgd),
        .red_sum({r_hi, r_lo}), .green_sum({g_hi, g_lo}), .blue_sum({b_hi, b_lo}),
        .Start_Sum(b_ss), .Start_BgRemoval(b_sbg), .Ack(b_ack),
        .red_exp(b_r), .green_exp(b_g), .blue_exp(b_b), .Busy(b_busy), .Done(b_done)
    );

    bg_frame_ctrl #(.NUM_PIXELS(3), .NUM_PROCS(1), .SUM_W(32)) dut_c (
        .Clk(clk), .Reset(rst), .Go(go && (sel == 2)), .Qsd(qsd[0]), .Qbgd(qbgd[0]),
        .red_sum(r_lo), .green_sum(g_lo), .blue_sum(b_lo),
        .Start_Sum(c_ss), .Start_BgRemoval(c_sbg), .Ack(c_ack),
        .red_exp(c_r), .green_exp(c_g), .blue_exp(c_b), .Busy(c_busy), .Done(c_done)
    );

    always_comb begin
        case (sel)
            1: {o_ss, o_sbg, o_ack, o_busy, o_done, o_r, o_g, o_b} =
               {b_ss, b_sbg, b_ack, b_busy, b_done, b_r, b_g, b_b};
            2: {o_ss, o_sbg, o_ack, o_busy, o_done, o_r, o_g, o_b} =
               {c_ss, c_sbg, c_ack, c_busy, c_done, c_r, c_g, c_b};
            default: {o_ss, o_sbg, o_ack, o_busy, o_done, o_r, o_g, o_b} =
               {a_ss, a_sbg, a_ack, a_busy, a_done, a_r, a_g, a_b};
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s sel=%0d actual=%0h required=%0h", name, sel, act, req);
        end
    endtask

    // Monitor: compares the colour presented with Start_BgRemoval and the per-frame pulse counts at Done
    initial begin
        forever begin
            @(negedge clk);
            if (!o_busy) begin
                ss_cnt  = 0;
                sbg_cnt = 0;
            end
            if (o_ss) ss_cnt++;
            if (o_sbg) begin
                sbg_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_bg_start", 64'(o_sbg), 64'(0));
                end else begin
                    check("exp_rgb", 64'({o_r, o_g, o_b}), 64'(exp_q.pop_front()));
                end
            end
            if (o_done) begin
                check("start_sum_per_frame", 64'(ss_cnt), 64'(1));
                check("start_bg_per_frame", 64'(sbg_cnt), 64'(1));
            end
        end
    end

    task automatic frame(input int s,
                         input logic [31:0] rl, input logic [31:0] rh,
                         input logic [31:0] gl, input logic [31:0] gh,
                         input logic [31:0] bl, input logic [31:0] bh,
                         input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                         input int totw, input bit hold01, input bit poke, input bit abort);
        int n;
        int bad;
        sel = s;
        r_lo = rl; r_hi = rh; g_lo = gl; g_hi = gh; b_lo = bl; b_hi = bh;
        if (!abort) exp_q.push_back({er, eg, eb});
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        check("start_sum", 64'(o_ss), 64'(1));
        @(negedge clk);
        check("ack_in_sum_wait", 64'(o_ack), 64'(1));
        if (poke) begin
            go = 1'b1; @(negedge clk); go = 1'b0;
        end
        if (hold01) begin
            qsd = 2'b01;
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (o_sbg || !o_ack) bad++;
            end
            check("hold_partial_qsd", 64'(bad), 64'(0));
        end
        qsd = 2'b11;
        if (abort) begin
            repeat (10) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("reset_mid_div", 64'({o_ss, o_sbg, o_ack, o_busy, o_done, o_r, o_g, o_b}), 64'(0));
            rst = 1'b0;
            qsd = 2'b00;
            @(negedge clk);
            return;
        end
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (o_sbg) break;
        end
        check("acc_div_cycles", 64'(n), 64'(totw + 2));
        qsd = 2'b00;
        @(negedge clk);
        if (poke) begin
            go = 1'b1; @(negedge clk); go = 1'b0;
        end
        qbgd = 2'b11;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (o_done) break;
        end
        check("done_latency", 64'(n), 64'(1));
        qbgd = 2'b00;
        @(negedge clk);
        check("busy_fall", 64'(o_busy), 64'(0));
        repeat (3) @(negedge clk);
        check("no_requeue", 64'({o_busy, o_ss}), 64'(0));
        check("exp_hold", 64'({o_r, o_g, o_b}), 64'({er, eg, eb}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; go = 1'b0; qsd = 2'b00; qbgd = 2'b00; sel = 0;
        r_lo = '0; r_hi = '0; g_lo = '0; g_hi = '0; b_lo = '0; b_hi = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset_state", 64'({o_ss, o_sbg, o_ack, o_busy, o_done, o_r, o_g, o_b}), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        // NUM_PROCS=1, NUM_PIXELS=4: plain averaging
        frame(0, 32'd387, 32'd0, 32'd399, 32'd0, 32'd594, 32'd0, 8'd96, 8'd99, 8'd148, 32, 1'b0, 1'b0, 1'b0);
        // saturation and zero
        frame(0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1019, 32'd0, 8'd255, 8'd0, 8'd254, 32, 1'b0, 1'b0, 1'b0);
        // NUM_PROCS=2: partial done flags must not advance
        frame(1, 32'd387, 32'd100, 32'd800, 32'd800, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              8'd60, 8'd200, 8'd255, 33, 1'b1, 1'b0, 1'b0);
        // NUM_PIXELS=3: truncation, Go pokes while busy
        frame(2, 32'd10, 32'd0, 32'd767, 32'd0, 32'd768, 32'd0, 8'd3, 8'd255, 8'd255, 32, 1'b0, 1'b1, 1'b0);
        // reset mid-DIV, then a clean frame
        frame(0, 32'd40, 32'd0, 32'd80, 32'd0, 32'd120, 32'd0, 8'd0, 8'd0, 8'd0, 32, 1'b0, 1'b0, 1'b1);
        frame(0, 32'd40, 32'd0, 32'd80, 32'd0, 32'd120, 32'd0, 8'd10, 8'd20, 8'd30, 32, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
